// File: rtl/motor_sequencer.sv
// Run/brake/fault sequencer between the SPI command decoder and the BLDC
// commutation stage. Turns command strobes into PWM-gated high-side and
// low-side enables, ramps duty toward a target, and supervises hall activity
// and command traffic. Any fault latches until an explicit clear command.
module motor_sequencer #(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned RAMP_DIV     = 1024,
  parameter logic [23:0] STALL_CYCLES = 24'd2000000,
  parameter logic [31:0] WDT_CYCLES   = 32'd50000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  input  logic                cmd_run,
  input  logic                cmd_brake,
  input  logic                cmd_clear,
  input  logic [PWM_BITS-1:0] cmd_duty,
  input  logic [2:0]          hal,
  output logic                enable_high,
  output logic                enable_low,
  output logic [PWM_BITS-1:0] duty_now,
  output logic [2:0]          state,
  output logic [1:0]          fault_code
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StBrake = 3'd1,
    StRamp  = 3'd2,
    StRun   = 3'd3,
    StFault = 3'd4
  } state_e;

  localparam logic [1:0] FaultNone    = 2'd0;
  localparam logic [1:0] FaultStall   = 2'd1;
  localparam logic [1:0] FaultWdt     = 2'd2;
  localparam logic [1:0] FaultIllegal = 2'd3;

  // Prescaler must hold RAMP_DIV-1; keep at least one bit for RAMP_DIV=1.
  localparam int unsigned       PrescW    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(RAMP_DIV - 1);

  // Hall synchroniser and edge history
  logic [2:0] hal_s1_q, hal_s2_q, hal_prev_q;
  logic       hal_edge, hal_illegal;

  // Datapath state
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [23:0]         stall_q, stall_d;
  logic [31:0]         wdt_q, wdt_d;
  state_e              state_q, state_d;
  logic [1:0]          fault_q, fault_d;
  logic                en_high_q, en_high_d;
  logic                en_low_q, en_low_d;

  // Decoded conditions
  logic                active;
  logic                pwm_on;
  logic                stall_hit, wdt_hit, ill_hit;
  logic                run_cmd;
  logic [PWM_BITS-1:0] ramp_tgt;

  // Two-flop synchroniser for the asynchronous hall inputs, plus history flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hal_s1_q   <= 3'b000;
      hal_s2_q   <= 3'b000;
      hal_prev_q <= 3'b000;
    end else begin
      hal_s1_q   <= hal;
      hal_s2_q   <= hal_s1_q;
      hal_prev_q <= hal_s2_q;
    end
  end

  // Condition decode feeding the next-state logic.
  always_comb begin
    active      = (state_q == StRamp) || (state_q == StRun);
    pwm_on      = pwm_cnt_q < duty_q;
    hal_edge    = hal_s2_q != hal_prev_q;
    hal_illegal = (hal_s2_q == 3'b000) || (hal_s2_q == 3'b111);
    // Terminal conditions fire on the cycle the counter would reach its limit.
    stall_hit   = (state_q == StRun) && !hal_edge && (duty_q != '0) &&
                  (stall_q >= STALL_CYCLES - 24'd1);
    wdt_hit     = active && (wdt_q >= WDT_CYCLES - 32'd1);
    ill_hit     = active && hal_illegal;
    run_cmd     = cmd_valid && cmd_run && !cmd_brake && (state_q != StFault);
    // A retarget in the same cycle as a ramp step steers that step too.
    ramp_tgt    = run_cmd ? cmd_duty : target_q;
  end

  // Next-state: counters, ramp, command decode, then faults (highest priority).
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    fault_d  = fault_q;
    presc_d  = '0;
    stall_d  = '0;
    wdt_d    = wdt_q;

    // Watchdog: any command clears; only counts while driving the motor.
    if (cmd_valid) begin
      wdt_d = '0;
    end else if (active && (wdt_q != WDT_CYCLES)) begin
      wdt_d = wdt_q + 32'd1;
    end

    // Stall counter lives only in RUN; zero elsewhere gives clear-on-entry.
    if ((state_q == StRun) && !hal_edge) begin
      stall_d = stall_q;
      if ((duty_q != '0) && (stall_q != STALL_CYCLES)) begin
        stall_d = stall_q + 24'd1;
      end
    end

    // Ramp: prescaler is zero outside RAMP, so it restarts on every entry.
    if (state_q == StRamp) begin
      presc_d = (presc_q == PrescLast) ? '0 : presc_q + PrescW'(1);
      if (duty_q == target_q) begin
        state_d = StRun;
      end else if (presc_q == PrescLast) begin
        if (duty_q < ramp_tgt) begin
          duty_d = duty_q + PWM_BITS'(1);
        end else if (duty_q > ramp_tgt) begin
          duty_d = duty_q - PWM_BITS'(1);
        end
      end
    end

    if (cmd_valid) begin
      if (state_q == StFault) begin
        if (cmd_clear) begin
          state_d = StIdle;
          fault_d = FaultNone;
        end
      end else if (cmd_brake) begin
        state_d = StBrake;
        duty_d  = '0;
      end else if (cmd_run) begin
        target_d = cmd_duty;
        if ((state_q != StRun) || (cmd_duty != duty_q)) begin
          state_d = StRamp;
        end
      end else begin
        // Coast: drop straight to idle with no ramp-down.
        state_d = StIdle;
        duty_d  = '0;
      end
    end

    if (stall_hit) begin
      state_d = StFault;
      fault_d = FaultStall;
      duty_d  = '0;
    end else if (wdt_hit) begin
      state_d = StFault;
      fault_d = FaultWdt;
      duty_d  = '0;
    end else if (ill_hit) begin
      state_d = StFault;
      fault_d = FaultIllegal;
      duty_d  = '0;
    end
  end

  // Enables follow the next state so FAULT/IDLE entry kills them on the same edge.
  always_comb begin
    en_high_d = ((state_d == StRamp) || (state_d == StRun)) && pwm_on;
    en_low_d  = (state_d == StBrake) || (state_d == StRamp) || (state_d == StRun);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      target_q  <= '0;
      presc_q   <= '0;
      stall_q   <= '0;
      wdt_q     <= '0;
      fault_q   <= FaultNone;
      en_high_q <= 1'b0;
      en_low_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      duty_q    <= duty_d;
      target_q  <= target_d;
      presc_q   <= presc_d;
      stall_q   <= stall_d;
      wdt_q     <= wdt_d;
      fault_q   <= fault_d;
      en_high_q <= en_high_d;
      en_low_q  <= en_low_d;
    end
  end

  // Output wiring.
  always_comb begin
    enable_high = en_high_q;
    enable_low  = en_low_q;
    duty_now    = duty_q;
    state       = state_q;
    fault_code  = fault_q;
  end

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with short ramp, stall and watchdog limits.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_motor_sequencer;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_run   = 1'b0;
  logic       cmd_brake = 1'b0;
  logic       cmd_clear = 1'b0;
  logic [7:0] cmd_duty  = 8'd0;
  logic [2:0] hal       = 3'b101;
  logic       enable_high;
  logic       enable_low;
  logic [7:0] duty_now;
  logic [2:0] state;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  motor_sequencer #(
    .PWM_BITS    (8),
    .RAMP_DIV    (4),
    .STALL_CYCLES(24'd100),
    .WDT_CYCLES  (32'd1000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_run    (cmd_run),
    .cmd_brake  (cmd_brake),
    .cmd_clear  (cmd_clear),
    .cmd_duty   (cmd_duty),
    .hal        (hal),
    .enable_high(enable_high),
    .enable_low (enable_low),
    .duty_now   (duty_now),
    .state      (state),
    .fault_code (fault_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a command for exactly one rising edge; returns on the next falling edge.
  task automatic send_cmd(input logic run, input logic brake, input logic clear,
                          input logic [7:0] duty);
    cmd_run   = run;
    cmd_brake = brake;
    cmd_clear = clear;
    cmd_duty  = duty;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_run   = 1'b0;
    cmd_brake = 1'b0;
    cmd_clear = 1'b0;
    cmd_duty  = 8'd0;
  endtask

  // Safety net against a hung run.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    int lo;

    // Reset
    #1 reset_n = 1'b0;
    step(3);
    check_eq("rst_state", state, 0);
    check_eq("rst_duty", duty_now, 0);
    check_eq("rst_en_high", enable_high, 0);
    check_eq("rst_en_low", enable_low, 0);
    check_eq("rst_fault", fault_code, 0);
    reset_n = 1'b1;
    step(3);

    // Run to duty 10: one LSB per 4 cycles, duty 10 after 40, RUN after 41.
    send_cmd(1'b1, 1'b0, 1'b0, 8'd10);
    check_eq("ramp_entry_state", state, 2);
    check_eq("ramp_entry_duty", duty_now, 0);
    check_eq("ramp_entry_en_low", enable_low, 1);
    step(3);
    check_eq("ramp_c3_duty", duty_now, 0);
    step(1);
    check_eq("ramp_c4_duty", duty_now, 1);
    step(35);
    check_eq("ramp_c39_duty", duty_now, 9);
    step(1);
    check_eq("ramp_c40_duty", duty_now, 10);
    check_eq("ramp_c40_state", state, 2);
    step(1);
    check_eq("run_state", state, 3);

    // One PWM period with hall toggling every 50 cycles: 10 of 256 high, no fault.
    hi = 0;
    lo = 0;
    for (int i = 0; i < 256; i++) begin
      if ((i % 50) == 49) hal = hal ^ 3'b001;
      @(negedge clk);
      hi += int'(enable_high);
      lo += int'(enable_low);
    end
    check_eq("pwm_high_count", hi, 10);
    check_eq("pwm_low_count", lo, 256);
    check_eq("toggle_no_fault", state, 3);

    // Ramp down 10 -> 4 takes 24 cycles, then stop coasts to IDLE.
    send_cmd(1'b1, 1'b0, 1'b0, 8'd4);
    check_eq("down_state", state, 2);
    step(23);
    check_eq("down_c23_duty", duty_now, 5);
    step(1);
    check_eq("down_c24_duty", duty_now, 4);
    step(1);
    check_eq("down_run_state", state, 3);
    send_cmd(1'b0, 1'b0, 1'b0, 8'd0);
    check_eq("stop_state", state, 0);
    check_eq("stop_duty", duty_now, 0);
    check_eq("stop_en_high", enable_high, 0);
    check_eq("stop_en_low", enable_low, 0);

    // Stall: hall edge then held; 2 sync cycles plus 100 counted cycles.
    send_cmd(1'b1, 1'b0, 1'b0, 8'd10);
    step(41);
    check_eq("stall_pre_state", state, 3);
    hal = hal ^ 3'b001;
    step(102);
    check_eq("stall_c101_state", state, 3);
    step(1);
    check_eq("stall_state", state, 4);
    check_eq("stall_code", fault_code, 1);
    check_eq("stall_en_high", enable_high, 0);
    check_eq("stall_en_low", enable_low, 0);
    check_eq("stall_duty", duty_now, 0);
    send_cmd(1'b0, 1'b0, 1'b1, 8'd0);
    check_eq("stall_clear_state", state, 0);

    // Watchdog: duty 0 so stall never counts; fault 1000 cycles after the command.
    send_cmd(1'b1, 1'b0, 1'b0, 8'd0);
    step(999);
    check_eq("wdt_c999_state", state, 3);
    check_eq("wdt_c999_en_high", enable_high, 0);
    step(1);
    check_eq("wdt_state", state, 4);
    check_eq("wdt_code", fault_code, 2);
    send_cmd(1'b1, 1'b0, 1'b0, 8'd5);
    check_eq("wdt_run_ignored_state", state, 4);
    check_eq("wdt_run_ignored_code", fault_code, 2);
    send_cmd(1'b0, 1'b0, 1'b1, 8'd0);
    check_eq("wdt_clear_state", state, 0);
    check_eq("wdt_clear_code", fault_code, 0);

    // Brake beats run.
    send_cmd(1'b1, 1'b1, 1'b0, 8'd10);
    check_eq("brake_state", state, 1);
    check_eq("brake_en_low", enable_low, 1);
    check_eq("brake_en_high", enable_high, 0);
    check_eq("brake_duty", duty_now, 0);

    // Illegal hall 111 in RUN: seen after the synchroniser, fault on the third edge.
    send_cmd(1'b1, 1'b0, 1'b0, 8'd10);
    step(41);
    check_eq("ill_pre_state", state, 3);
    hal = 3'b111;
    step(2);
    check_eq("ill_c2_state", state, 3);
    step(1);
    check_eq("ill_state", state, 4);
    check_eq("ill_code", fault_code, 3);
    hal = 3'b101;
    step(2);
    send_cmd(1'b0, 1'b0, 1'b1, 8'd0);
    check_eq("ill_clear_code", fault_code, 0);

    // Stall terminal count on the same edge as a brake command: stall wins.
    send_cmd(1'b1, 1'b0, 1'b0, 8'd10);
    step(41);
    hal = hal ^ 3'b001;
    step(102);
    check_eq("coinc_pre_state", state, 3);
    send_cmd(1'b0, 1'b1, 1'b0, 8'd0);
    check_eq("coinc_state", state, 4);
    check_eq("coinc_code", fault_code, 1);
    send_cmd(1'b0, 1'b0, 1'b1, 8'd0);

    // Asynchronous reset in the middle of a ramp.
    send_cmd(1'b1, 1'b0, 1'b0, 8'd10);
    step(20);
    check_eq("areset_pre_duty", duty_now, 5);
    check_eq("areset_pre_en_low", enable_low, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("areset_state", state, 0);
    check_eq("areset_duty", duty_now, 0);
    check_eq("areset_en_low", enable_low, 0);
    check_eq("areset_en_high", enable_high, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    check_eq("areset_release_state", state, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
Run/brake/fault sequencer sitting between the SPI command decoder and the BLDC commutation block. It turns one-cycle command pulses into the enable_high/enable_low controls for the commutation stage. A high-side PWM gate ramps its duty toward a commanded target. The block supervises hall activity (stall and illegal codes) and command traffic (watchdog), forcing a latched fault that only an explicit clear command releases.

Parameters:
PWM_BITS, 8, width of duty and of the free-running PWM counter
RAMP_DIV, 1024, clock cycles per single-LSB duty step while ramping
STALL_CYCLES, 24'd2000000, cycles without a hall edge in RUN before stall fault
WDT_CYCLES, 32'd50000000, cycles without cmd_valid in RAMP/RUN before watchdog fault

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  one-cycle strobe qualifying cmd_* fields
cmd_run  in  1  1 = run, 0 = stop (coast)
cmd_brake  in  1  1 = brake; has priority over cmd_run
cmd_clear  in  1  clear latched fault; only honoured in FAULT
cmd_duty  in  PWM_BITS  target duty
hal  in  3  raw hall inputs, asynchronous
enable_high  out  1  high-side enable to commutation block, PWM-gated
enable_low  out  1  low-side enable to commutation block
duty_now  out  PWM_BITS  current ramped duty
state  out  3  IDLE=0, BRAKE=1, RAMP=2, RUN=3, FAULT=4
fault_code  out  2  0 none, 1 stall, 2 watchdog, 3 illegal hall

Behaviour:
- Reset (reset_n=0, async): state=IDLE, all outputs 0, target=0, all counters 0.
- hal passes through a 2-flop synchroniser. hal_edge = synchronised value differs from its previous registered value. Illegal code = 000 or 111 on the synchronised value.
- PWM counter is free-running, 0..2^PWM_BITS-1, and wraps.
- pwm_on = (pwm_cnt < duty_now). Duty 0 gives never on. Duty 255 gives 255 of 256 cycles on.
- Registered outputs; enable_high lags the pwm compare by 1 cycle.
- Outputs per state:
  - IDLE: high=0, low=0, duty_now=0.
  - BRAKE: high=0, low=1, duty_now=0.
  - RAMP/RUN: high=pwm_on, low=1.
  - FAULT: high=0, low=0, duty_now=0.
- Command decode on cmd_valid, in priority order:
  - In FAULT: cmd_clear=1 goes to IDLE with fault_code=0. Every other command is ignored.
  - Otherwise, cmd_brake=1 goes to BRAKE with duty_now=0.
  - Otherwise, cmd_run=1 latches target=cmd_duty and goes to RAMP. This also applies from RUN when cmd_duty differs from duty_now.
  - Otherwise, go to IDLE immediately with duty_now=0 (coast, no ramp-down).
  - cmd_clear outside FAULT is ignored.
- RAMP:
  - Ramp prescaler clears on RAMP entry and counts 0..RAMP_DIV-1.
  - At terminal count, duty_now moves 1 LSB toward target, up or down.
  - When duty_now==target (checked every cycle, including on entry), go to RUN.
  - A new run command during RAMP retargets without clearing the prescaler.
- RUN:
  - Stall counter clears on RUN entry and on every hal_edge. It increments otherwise, but only while duty_now != 0.
  - Counter reaching STALL_CYCLES sends the block to FAULT with code 1.
- Watchdog:
  - Counter clears on every cmd_valid, in every state, and increments only in RAMP/RUN.
  - Reaching WDT_CYCLES sends the block to FAULT with code 2.
- Illegal hall code sampled in RAMP or RUN sends the block to FAULT with code 3.
- Simultaneous events:
  - A fault condition beats cmd_valid in the same cycle.
  - Fault priority is stall (1) > watchdog (2) > illegal hall (3).
  - fault_code latches on FAULT entry and holds until clear.
- Entry into FAULT forces enable_high and enable_low to 0 on the next clock edge.
- Reset mid-operation: outputs go to 0 asynchronously, with no ramp-down.
- Counter behaviour at limits:
  - Stall and watchdog counters saturate and never wrap.
  - duty_now never overshoots target and never wraps past 0 or max.

Test Plan:
Use RAMP_DIV=4, STALL_CYCLES=100, WDT_CYCLES=1000, PWM_BITS=8.
- Reset then run: cmd run, duty=10 -> RAMP. duty_now increments every 4 cycles and reaches 10 at 40 cycles, then state=RUN. enable_high high for 10 of every 256 cycles. enable_low=1.
- Ramp down and stop: in RUN at 10, cmd run duty=4 -> duty_now reaches 4 after 24 cycles. Then cmd stop -> IDLE next cycle, both enables 0, duty_now=0.
- Stall: in RUN at duty 10, hal held at 101 -> FAULT, fault_code=1, exactly 100 cycles after the last hall edge. Toggling hal every 50 cycles must never fault.
- Watchdog and clear: run with no further cmd_valid -> FAULT code 2 at 1000 cycles. Then cmd run (no clear) -> stays FAULT. cmd_clear -> IDLE, fault_code=0.
- Brake priority and illegal hall: cmd with brake=1 and run=1 -> BRAKE, low=1, high=0. In RUN, hal=111 for 3 cycles -> FAULT code 3. If stall terminal count coincides with cmd_valid, FAULT code 1 wins.
- Async reset: assert reset_n low mid-RAMP, between clock edges -> all outputs 0 immediately. After release -> state=IDLE.
